// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: shared FSM encoding and default FIFO geometry
package uart_tx_fifo_pkg;
  localparam int DEPTH_DEF = 16;
  localparam int AW_DEF = 4;
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/uart_fifo_ram.sv
// uart_fifo_ram: DEPTH x 8 storage, synchronous write, asynchronous read
module uart_fifo_ram
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);
  logic [7:0] mem_q [DEPTH];
  // storage needs no reset; only written entries are ever read
  always_ff @(posedge clk_i)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART serializer with one-cycle launch pulses
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW = AW_DEF
) (
  input  logic        PCLK,
  input  logic        PRESET,
  input  logic        i_Enable,
  input  logic        i_Wr_En,
  input  logic [7:0]  i_Wr_Byte,
  input  logic        i_Flush,
  input  logic        i_Ovf_Clr,
  input  logic        i_TX_Done,
  output logic        o_TX_DV,
  output logic [7:0]  o_TX_Byte,
  output logic        o_Full,
  output logic        o_Empty,
  output logic [AW:0] o_Count,
  output logic        o_Busy,
  output logic        o_Overflow
);
  state_e        state_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, empty_q, ovf_q, ovf_d, tx_dv_q;
  logic [7:0]    tx_byte_q, rd_data;
  logic          push, launch, ovf_set;

  uart_fifo_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk_i   (PCLK),
    .we_i    (push),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_Wr_Byte),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_data)
  );

  // flush wins over push and launch; a full FIFO refuses pushes even when popping
  always_comb begin
    launch   = state_q == IDLE && i_Enable && !empty_q && !i_Flush;
    push     = i_Wr_En && !full_q && !i_Flush;
    ovf_set  = i_Wr_En && full_q && !i_Flush;
    wr_ptr_d = i_Flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = i_Flush ? '0 : rd_ptr_q + AW'(launch);
    count_d  = i_Flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(launch);
    ovf_d    = ovf_set || (ovf_q && !i_Ovf_Clr);
  end

  // pointers, count and status flags, all registered from next-state count
  always_ff @(posedge PCLK)
    if (PRESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= count_d == (AW+1)'(DEPTH);
      empty_q  <= count_d == '0;
      ovf_q    <= ovf_d;
    end

  // launch FSM with registered strobe and byte
  always_ff @(posedge PCLK)
    if (PRESET) begin
      state_q   <= IDLE;
      tx_dv_q   <= 1'b0;
      tx_byte_q <= 8'h00;
    end else begin
      tx_dv_q <= launch;
      if (launch) tx_byte_q <= rd_data;
      case (state_q)
        IDLE:      if (launch) state_q <= LAUNCH;
        LAUNCH:    state_q <= WAIT_DONE;
        WAIT_DONE: if (i_TX_Done) state_q <= IDLE;
        default:   state_q <= IDLE;
      endcase
    end

  assign o_TX_DV    = tx_dv_q;
  assign o_TX_Byte  = tx_byte_q;
  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Busy     = state_q != IDLE;
  assign o_Overflow = ovf_q;
endmodule
